dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-mapped data-memory responder for the pipelined core's load/store port. The core initiates; this block answers.
- Accepts one request at a time and performs RV32I byte, halfword and word loads/stores with sign or zero extension.
- Returns each response after a programmable latency.
- Provides a sticky halt register that the core writes to end simulation deterministically, instead of relying on a fixed timeout.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte range is 0 to DEPTH_WORDS*4-1.
- LATENCY, 1: cycles from the accept edge to response-valid; must be >= 1.
- HALT_ADDR, 32'h0000_1000: word address of the halt register; must lie outside the memory range.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  RV32I load/store funct3.
- rsp_valid  out  1  response valid; single-cycle pulse.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  access fault.
- halt  out  1  sticky halt flag.
- halt_code  out  32  value written to the halt register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, halt=0, halt_code=0, wait counter=0.
  - req_ready=0 while reset is low.
  - Memory contents are not reset.
- req_ready = reset high AND state==IDLE.
- A request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge.
- FSM:
  - IDLE -> WAIT on accept if LATENCY>1; the counter loads LATENCY-1.
  - IDLE -> RESP on accept if LATENCY==1.
  - WAIT: counter decrements each cycle; when it reaches 1, next state is RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - There is no response backpressure; the core always takes the response.
- Timing:
  - Accept at edge N; rsp_valid is high in the cycle following edge N+LATENCY-1.
  - Throughput is one transaction per LATENCY+1 cycles, because IDLE costs one cycle.
- rsp_rdata and rsp_err are registered, are stable while rsp_valid=1, and clear to 0 when leaving RESP.
- Stores commit to memory at the accept edge. There is only one outstanding request, so a following load always sees the store.
- Store lanes:
  - SB (000): write lane addr[1:0] with wdata[7:0].
  - SH (001): write lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
  - SW (010): write all four lanes.
- Load extraction from the word at addr[31:2]:
  - LB (000): selected byte, sign-extended.
  - LH (001): selected halfword, sign-extended.
  - LW (010): full word.
  - LBU (100): selected byte, zero-extended.
  - LHU (101): selected halfword, zero-extended.
- Errors set rsp_err=1 and rsp_rdata=0, and suppress any memory or halt write. An access is an error if any of these hold:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - funct3 011, 110 or 111.
  - funct3 100 or 101 with req_we=1.
  - Address >= DEPTH_WORDS*4 and not equal to HALT_ADDR.
  - Any non-word access to HALT_ADDR.
- Halt register:
  - SW to HALT_ADDR while halt=0 sets halt=1 and halt_code=wdata at the accept edge.
  - While halt=1, further SW to HALT_ADDR is accepted with rsp_err=0 but ignored; the first write wins.
  - LW from HALT_ADDR returns halt_code.
  - halt and halt_code clear only on reset.
  - The block keeps serving requests after halt.
- Reset mid-transaction (in WAIT or RESP):
  - Immediate return to IDLE with all outputs at reset values; no response is emitted later.
  - A store accepted before reset remains in memory.
- Simultaneous events: req_valid while not IDLE is ignored (req_ready=0). The core must hold the request until it is accepted.

Test Plan:
1. Release reset; SW 0xDEADBEEF @0x10, then LW @0x10 with LATENCY=1 -> each rsp_valid pulses 1 cycle after accept; load rsp_rdata=0xDEADBEEF, rsp_err=0; store rsp_rdata=0.
2. After test 1, SB wdata=0x80 @0x13 -> LB @0x13=0xFFFFFF80; LBU @0x13=0x00000080; LW @0x10=0x80ADBEEF; LH @0x12=0xFFFF80AD; LHU @0x12=0x000080AD.
3. LH @0x11 -> rsp_err=1, rsp_rdata=0. SW 0x12345678 @0x12 -> rsp_err=1, and LW @0x10 still reads 0x80ADBEEF. LW @0x2000 -> rsp_err=1. funct3=011 -> rsp_err=1.
4. SW 0x1 @HALT_ADDR -> halt=1 and halt_code=1 right after the accept edge. SW 0x5 @HALT_ADDR -> rsp_err=0, halt_code stays 1. LW @HALT_ADDR -> rsp_rdata=1. SB @HALT_ADDR -> rsp_err=1.
5. LATENCY=3, req_valid held high continuously -> req_ready pattern 1,0,0,0 repeating; rsp_valid in the 4th cycle of each group; 3 loads complete in 12 cycles.
6. LATENCY=3: accept SW 0xA5A5A5A5 @0x20, assert reset during WAIT -> rsp_valid=0 immediately and no later pulse; halt=0. After release, LW @0x20=0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: RV32I sub-word
// loads/stores, programmable response latency and a sticky halt register.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] HALT_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        halt,
    output logic [31:0] halt_code
);
    localparam int unsigned ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W     = $clog2(LATENCY + 1);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       res_rdata_q, res_rdata_d;
    logic              res_err_q, res_err_d;
    logic              halt_q;
    logic [31:0]       halt_code_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              accept;
    logic              is_halt;
    logic              in_range;
    logic              acc_err;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       ld_data;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              mem_we;
    logic              halt_we;

    assign req_ready = reset && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign is_halt   = (req_addr == HALT_ADDR);
    assign in_range  = (req_addr < MEM_BYTES);
    assign word_idx  = req_addr[ADDR_W+1:2];
    assign mem_we    = accept && req_we && !acc_err && !is_halt;
    assign halt_we   = accept && req_we && !acc_err && is_halt && !halt_q;

    // Access legality: alignment, funct3 encoding, address decode.
    always_comb begin
        acc_err = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: acc_err = 1'b0;
            3'b001, 3'b101: acc_err = req_addr[0];
            3'b010:         acc_err = |req_addr[1:0];
            default:        acc_err = 1'b1;
        endcase
        if (req_we && req_funct3[2])           acc_err = 1'b1;
        if (!in_range && !is_halt)             acc_err = 1'b1;
        if (is_halt && req_funct3 != 3'b010)   acc_err = 1'b1;
    end

    // Load extraction and extension; stores and faults return zero.
    always_comb begin
        rd_word = is_halt ? halt_code_q : mem_q[word_idx];
        case (req_addr[1:0])
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_funct3)
            3'b000:  ld_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  ld_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, sel_byte};
            3'b101:  ld_data = {16'd0, sel_half};
            default: ld_data = 32'd0;
        endcase
        if (acc_err || req_we) ld_data = 32'd0;
    end

    // Store lane enables with data replicated across lanes.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                wr_data = {4{req_wdata[7:0]}};
                wr_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{req_wdata[15:0]}};
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = req_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    res_rdata_d = ld_data;
                    res_err_d   = acc_err;
                    if (LATENCY == 1) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_data;
                        rsp_err_d   = acc_err;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = res_rdata_q;
                    rsp_err_d   = res_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            res_rdata_q <= 32'd0;
            res_err_q   <= 1'b0;
            halt_q      <= 1'b0;
            halt_code_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
            if (halt_we) begin
                halt_q      <= 1'b1;
                halt_code_q <= req_wdata;
            end
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=1 and one at LATENCY=3,
// checked against directed vectors and a byte-array reference model.
module tb_dmem_responder;
    localparam logic [31:0] HALT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n;
    logic        sel;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        v0, v1;
    logic        rdy0, rdy1, rv0, rv1, re0, re1, hl0, hl1;
    logic [31:0] rd0, rd1, hc0, hc1;
    logic        rdy_s, rv_s, re_s, hl_s;
    logic [31:0] rd_s, hc_s;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mm [2][4096];
    logic        halt_m [2];
    logic [31:0] hcode_m [2];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vt [21];

    always #5 clk = ~clk;

    assign v0    = req_valid && !sel;
    assign v1    = req_valid && sel;
    assign rdy_s = sel ? rdy1 : rdy0;
    assign rv_s  = sel ? rv1 : rv0;
    assign re_s  = sel ? re1 : re0;
    assign hl_s  = sel ? hl1 : hl0;
    assign rd_s  = sel ? rd1 : rd0;
    assign hc_s  = sel ? hc1 : hc0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .HALT_ADDR(HALT)) u_lat1 (
        .clk(clk), .reset(rst0_n), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0), .halt(hl0), .halt_code(hc0));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .HALT_ADDR(HALT)) u_lat3 (
        .clk(clk), .reset(rst1_n), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .halt(hl1), .halt_code(hc1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32I access rules applied to a byte-addressed array.
    task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
        int unsigned size;
        logic [31:0] v;
        size = 32'd1 << f3[1:0];
        err = (f3[1:0] == 2'd3) || (f3 > 3'd5) || (we && f3[2]) || ((addr % size) != 0)
              || (addr >= 32'd4096 && addr != HALT) || (addr == HALT && size != 4);
        rdata = 32'd0;
        if (!err) begin
            if (addr == HALT) begin
                if (we) begin
                    if (!halt_m[d]) begin
                        halt_m[d]  = 1'b1;
                        hcode_m[d] = wdata;
                    end
                end else begin
                    rdata = hcode_m[d];
                end
            end else if (we) begin
                for (int i = 0; i < int'(size); i++) mm[d][addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < int'(size); i++) v = v | (32'(mm[d][addr + 32'(i)]) << (8*i));
                if (!f3[2] && size < 4 && mm[d][addr + size - 1][7]) v = v | (32'hFFFF_FFFF << (8*size));
                rdata = v;
            end
        end
    endtask

    // Issue one request, check halt right after accept, latency and pulse width.
    task automatic txn(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output logic [31:0] m_rd, output logic m_err);
        int n;
        int lat;
        sel = (d == 1);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!rdy_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready low for %0d cycles", n);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        model_access(d, we, f3, addr, wdata, m_err, m_rd);
        chk("halt_after_accept", 32'(hl_s), 32'(halt_m[d]));
        chk("halt_code_after_accept", hc_s, hcode_m[d]);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv_s && lat < 20);
        chk("latency", lat, (d == 1) ? 32'd3 : 32'd1);
        rdata = rd_s;
        err   = re_s;
        @(negedge clk);
        chk("rsp_single_pulse", 32'(rv_s), 32'd0);
        chk("rdata_cleared", rd_s, 32'd0);
        chk("err_cleared", 32'(re_s), 32'd0);
    endtask

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic random_phase(input int d, input int nops);
        logic [31:0] rd, mrd, addr;
        logic        er, mer, we;
        logic [2:0]  f3;
        int          r;
        for (int w = 0; w < 16; w++) begin
            txn(d, 1'b1, 3'b010, 32'h100 + 32'(4*w), $urandom, rd, er, mrd, mer);
            chk("rand_init_err", 32'(er), 32'(mer));
        end
        for (int k = 0; k < nops; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       addr = 32'h100 + 32'($urandom_range(0, 63));
            else if (r == 8) addr = HALT;
            else             addr = 32'h1000 + 32'($urandom_range(1, 32'hFFFF));
            f3 = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            txn(d, we, f3, addr, $urandom, rd, er, mrd, mer);
            chk("rand_rdata", rd, mrd);
            chk("rand_err", 32'(er), 32'(mer));
        end
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          pulses;
        int          nld;

        for (int d = 0; d < 2; d++) begin
            halt_m[d] = 1'b0;
            hcode_m[d] = 32'd0;
            for (int i = 0; i < 4096; i++) mm[d][i] = 8'd0;
        end
        rst0_n = 1'b0; rst1_n = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;

        #3;
        chk("reset_ready0", 32'(rdy0), 32'd0);
        chk("reset_ready1", 32'(rdy1), 32'd0);
        chk("reset_rsp_valid", 32'(rv0 | rv1), 32'd0);
        chk("reset_rdata", rd0 | rd1, 32'd0);
        chk("reset_halt", 32'(hl0 | hl1), 32'd0);
        chk("reset_halt_code", hc0 | hc1, 32'd0);
        repeat (3) @(negedge clk);
        rst0_n = 1'b1; rst1_n = 1'b1;
        #1;
        chk("ready_after_reset0", 32'(rdy0), 32'd1);
        chk("ready_after_reset1", 32'(rdy1), 32'd1);

        vt[0]  = mk(1, 3'b010, 32'h10,   32'hDEAD_BEEF, 32'h0000_0000, 0);
        vt[1]  = mk(0, 3'b010, 32'h10,   32'h0,         32'hDEAD_BEEF, 0);
        vt[2]  = mk(1, 3'b000, 32'h13,   32'h80,        32'h0000_0000, 0);
        vt[3]  = mk(0, 3'b000, 32'h13,   32'h0,         32'hFFFF_FF80, 0);
        vt[4]  = mk(0, 3'b100, 32'h13,   32'h0,         32'h0000_0080, 0);
        vt[5]  = mk(0, 3'b010, 32'h10,   32'h0,         32'h80AD_BEEF, 0);
        vt[6]  = mk(0, 3'b001, 32'h12,   32'h0,         32'hFFFF_80AD, 0);
        vt[7]  = mk(0, 3'b101, 32'h12,   32'h0,         32'h0000_80AD, 0);
        vt[8]  = mk(0, 3'b001, 32'h11,   32'h0,         32'h0,         1);
        vt[9]  = mk(1, 3'b010, 32'h12,   32'h1234_5678, 32'h0,         1);
        vt[10] = mk(0, 3'b010, 32'h10,   32'h0,         32'h80AD_BEEF, 0);
        vt[11] = mk(0, 3'b010, 32'h2000, 32'h0,         32'h0,         1);
        vt[12] = mk(0, 3'b011, 32'h10,   32'h0,         32'h0,         1);
        vt[13] = mk(1, 3'b100, 32'h10,   32'h55,        32'h0,         1);
        vt[14] = mk(1, 3'b001, 32'h12,   32'hCAFE_1234, 32'h0,         0);
        vt[15] = mk(0, 3'b010, 32'h10,   32'h0,         32'h1234_BEEF, 0);
        vt[16] = mk(1, 3'b010, HALT,     32'h1,         32'h0,         0);
        vt[17] = mk(1, 3'b010, HALT,     32'h5,         32'h0,         0);
        vt[18] = mk(0, 3'b010, HALT,     32'h0,         32'h1,         0);
        vt[19] = mk(1, 3'b000, HALT,     32'h7,         32'h0,         1);
        vt[20] = mk(0, 3'b010, 32'h1004, 32'h0,         32'h0,         1);

        for (int i = 0; i < 21; i++) begin
            txn(0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, mrd, mer);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
        end
        chk("halt_sticky", 32'(hl0), 32'd1);
        chk("halt_first_write_wins", hc0, 32'd1);

        random_phase(0, 60);

        // Back-to-back loads with req_valid held high at LATENCY=3.
        txn(1, 1'b1, 3'b010, 32'h30, 32'h0BAD_F00D, rd, er, mrd, mer);
        sel = 1'b1;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30; req_valid = 1'b1;
        nld = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("t5_ready_c%0d", c), 32'(rdy1), (c % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t5_rspv_c%0d", c), 32'(rv1), (c % 4 == 3) ? 32'd1 : 32'd0);
            if (rv1) begin
                nld++;
                chk("t5_rdata", rd1, 32'h0BAD_F00D);
            end
        end
        req_valid = 1'b0;
        chk("t5_loads_done", nld, 32'd3);

        // Reset during WAIT drops the response; the store survives.
        txn(1, 1'b1, 3'b010, HALT, 32'h77, rd, er, mrd, mer);
        chk("t6_halt_set", 32'(hl1), 32'd1);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        model_access(1, 1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5, mer, mrd);
        @(negedge clk);
        rst1_n = 1'b0;
        #1;
        halt_m[1] = 1'b0;
        hcode_m[1] = 32'd0;
        chk("t6_rspv_in_reset", 32'(rv1), 32'd0);
        chk("t6_ready_in_reset", 32'(rdy1), 32'd0);
        chk("t6_halt_cleared", 32'(hl1), 32'd0);
        chk("t6_halt_code_cleared", hc1, 32'd0);
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv1) pulses++;
        end
        chk("t6_no_late_rsp", pulses, 32'd0);
        txn(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, mrd, mer);
        chk("t6_store_kept", rd, 32'hA5A5_A5A5);
        chk("t6_store_kept_err", 32'(er), 32'd0);

        random_phase(1, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
